// File: rtl/axi_burst_seq_pkg.sv
// Shared types and helpers for the AXI burst command sequencer:
// FSM state encoding, pattern lane width, lane pattern and saturating add.
package axi_burst_seq_pkg;

   localparam int LANE_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_ISSUE = 3'd1,
      ST_WR_DATA  = 3'd2,
      ST_RD_ISSUE = 3'd3,
      ST_RD_DATA  = 3'd4,
      ST_NEXT     = 3'd5,
      ST_DONE     = 3'd6
   } seq_state_t;

   // One 32-bit pattern lane: seed + (t << 4) + b, wrapping mod 2^32.
   function automatic logic [LANE_W-1:0] word(input logic [7:0]        t,
                                              input logic [4:0]        b,
                                              input logic [LANE_W-1:0] seed);
      word = seed + {20'd0, t, 4'd0} + {27'd0, b};
   endfunction

   // Adds up to two error events to the mismatch counter, clamping at all-ones.
   function automatic logic [15:0] sat_add(input logic [15:0] a,
                                           input logic [1:0]  inc);
      logic [16:0] sum;
      sum = {1'b0, a} + {15'd0, inc};
      if (sum > 17'h0_FFFF) begin
         sat_add = 16'hFFFF;
      end else begin
         sat_add = sum[15:0];
      end
   endfunction

endpackage

// File: rtl/axi_burst_seq_pattern.sv
// Combinational data pattern for transaction t, beat b: the 32-bit lane
// replicated across the full data width.
module axi_burst_seq_pattern
   import axi_burst_seq_pkg::*;
#(
   parameter int          DATA_W       = 64,
   parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000
) (
   input  logic [7:0]        txn,
   input  logic [4:0]        beat,
   output logic [DATA_W-1:0] data
);

   logic [LANE_W-1:0] lane_s;

   assign lane_s = word(txn, beat, PATTERN_SEED);
   assign data   = {(DATA_W/LANE_W){lane_s}};

endmodule

// File: rtl/axi_burst_seq.sv
// Command sequencer in front of the AXI burst traffic generator: runs
// NUM_TXN write-then-readback burst pairs at consecutive addresses, checks
// every read beat against the pattern and reports mismatches, response
// errors and watchdog expiry.
module axi_burst_seq
   import axi_burst_seq_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 64,
   parameter int                NUM_TXN      = 4,
   parameter int                BURST_LEN    = 3,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'h0000_1000),
   parameter logic [ADDR_W-1:0] ADDR_STRIDE  = ADDR_W'(32'h0000_0100),
   parameter logic [31:0]       PATTERN_SEED = 32'hA5A5_0000,
   parameter int                TIMEOUT_CYC  = 1024
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                cfg_start,
   output logic                busy,
   output logic                done,
   output logic [15:0]         err_count,
   output logic                resp_err,
   output logic                timeout,
   output logic                tg_start,
   output logic                tg_w_r,
   output logic [3:0]          tg_burst_len,
   output logic [DATA_W/8-1:0] tg_data_strb,
   output logic [DATA_W-1:0]   tg_data,
   output logic [ADDR_W-1:0]   tg_addr,
   input  logic                tg_free,
   input  logic                tg_stall_w_data,
   input  logic [1:0]          tg_status,
   input  logic [DATA_W-1:0]   tg_data_out,
   input  logic                tg_data_out_en
);

   localparam logic [7:0]  TXN_LAST = 8'(NUM_TXN - 1);
   localparam logic [3:0]  BLEN4    = 4'(BURST_LEN);
   localparam logic [4:0]  BLEN5    = 5'(BURST_LEN);
   localparam logic [4:0]  BEATS    = 5'(BURST_LEN + 1);
   localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYC);

   seq_state_t  state_r, state_n;
   logic [7:0]  t_r, t_n;
   logic [4:0]  b_r, b_n;
   logic [31:0] wd_r, wd_n;
   logic [15:0] err_count_r, err_n;
   logic        resp_err_r, resp_n;
   logic        timeout_r, to_n;

   logic              wr_phase_s;
   logic              wait_state_s;
   logic              beat_evt_s;
   logic [1:0]        mis_s;
   logic [DATA_W-1:0] wr_data_s;
   logic [DATA_W-1:0] exp_data_s;
   logic [ADDR_W-1:0] addr_s;

   // Write data source for the current transaction/beat.
   axi_burst_seq_pattern #(
      .DATA_W       (DATA_W),
      .PATTERN_SEED (PATTERN_SEED)
   ) u_wr_pat (
      .txn  (t_r),
      .beat (b_r),
      .data (wr_data_s)
   );

   // Expected read data for the current transaction/beat.
   axi_burst_seq_pattern #(
      .DATA_W       (DATA_W),
      .PATTERN_SEED (PATTERN_SEED)
   ) u_rd_pat (
      .txn  (t_r),
      .beat (b_r),
      .data (exp_data_s)
   );

   assign addr_s       = BASE_ADDR + (ADDR_W'(t_r) * ADDR_STRIDE);
   assign wr_phase_s   = (state_r == ST_WR_ISSUE) || (state_r == ST_WR_DATA);
   assign wait_state_s = (state_r == ST_WR_ISSUE) || (state_r == ST_WR_DATA) ||
                         (state_r == ST_RD_ISSUE) || (state_r == ST_RD_DATA);

   // Outputs decode registered state only, so no input reaches them combinationally.
   assign busy         = (state_r != ST_IDLE);
   assign done         = (state_r == ST_DONE);
   assign tg_start     = (state_r == ST_WR_ISSUE) || (state_r == ST_RD_ISSUE);
   assign tg_w_r       = (state_r == ST_RD_ISSUE) || (state_r == ST_RD_DATA);
   assign tg_burst_len = busy ? BLEN4 : 4'd0;
   assign tg_data_strb = wr_phase_s ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};
   assign tg_data      = wr_phase_s ? wr_data_s : {DATA_W{1'b0}};
   assign tg_addr      = busy ? addr_s : {ADDR_W{1'b0}};
   assign err_count    = err_count_r;
   assign resp_err     = resp_err_r;
   assign timeout      = timeout_r;

   // Next-state, beat/txn counters, result flags and watchdog.
   always_comb begin
      state_n    = state_r;
      t_n        = t_r;
      b_n        = b_r;
      wd_n       = wd_r;
      err_n      = err_count_r;
      to_n       = timeout_r;
      beat_evt_s = 1'b0;
      mis_s      = 2'd0;

      // Generator status is registered, so the last response lands in NEXT/DONE.
      if (state_r != ST_IDLE) begin
         resp_n = resp_err_r | (tg_status != 2'b00);
      end else if (cfg_start) begin
         resp_n = 1'b0;
      end else begin
         resp_n = resp_err_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (cfg_start) begin
               err_n   = 16'd0;
               to_n    = 1'b0;
               t_n     = 8'd0;
               b_n     = 5'd0;
               state_n = ST_WR_ISSUE;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_WR_ISSUE: begin
            b_n = 5'd0;
            if (!tg_free) begin
               state_n = ST_WR_DATA;
            end else begin
               state_n = ST_WR_ISSUE;
            end
         end
         ST_WR_DATA: begin
            // Mirror the generator's beat counter so tg_data tracks wready.
            if (tg_stall_w_data) begin
               beat_evt_s = 1'b1;
               if (b_r < BLEN5) begin
                  b_n = b_r + 5'd1;
               end else begin
                  b_n = b_r;
               end
            end else begin
               b_n = b_r;
            end
            if (tg_free) begin
               state_n = ST_RD_ISSUE;
            end else begin
               state_n = ST_WR_DATA;
            end
         end
         ST_RD_ISSUE: begin
            b_n = 5'd0;
            if (!tg_free) begin
               state_n = ST_RD_DATA;
            end else begin
               state_n = ST_RD_ISSUE;
            end
         end
         ST_RD_DATA: begin
            if (tg_data_out_en) begin
               beat_evt_s = 1'b1;
               b_n        = b_r + 5'd1;
               if (tg_data_out != exp_data_s) begin
                  mis_s = mis_s + 2'd1;
               end else begin
                  mis_s = mis_s;
               end
            end else begin
               b_n = b_r;
            end
            // A burst that ends with the wrong beat count is one more error.
            if (tg_free) begin
               state_n = ST_NEXT;
               if (b_n != BEATS) begin
                  mis_s = mis_s + 2'd1;
               end else begin
                  mis_s = mis_s;
               end
            end else begin
               state_n = ST_RD_DATA;
            end
            err_n = sat_add(err_count_r, mis_s);
         end
         ST_NEXT: begin
            if (t_r == TXN_LAST) begin
               state_n = ST_DONE;
            end else begin
               t_n     = t_r + 8'd1;
               state_n = ST_WR_ISSUE;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // Watchdog: an accepted beat or a state change restarts it and wins over expiry.
      if ((state_n != state_r) || beat_evt_s) begin
         wd_n = 32'd0;
      end else if (wait_state_s && (TO_LIMIT != 32'd0)) begin
         if ((wd_r + 32'd1) == TO_LIMIT) begin
            to_n    = 1'b1;
            state_n = ST_DONE;
            wd_n    = 32'd0;
         end else begin
            wd_n = wd_r + 32'd1;
         end
      end else begin
         wd_n = 32'd0;
      end
   end

   // State, counters and sticky results; reset aborts any run immediately.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r     <= ST_IDLE;
         t_r         <= 8'd0;
         b_r         <= 5'd0;
         wd_r        <= 32'd0;
         err_count_r <= 16'd0;
         resp_err_r  <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         state_r     <= state_n;
         t_r         <= t_n;
         b_r         <= b_n;
         wd_r        <= wd_n;
         err_count_r <= err_n;
         resp_err_r  <= resp_n;
         timeout_r   <= to_n;
      end
   end

endmodule

// File: tb/tb_axi_burst_seq.sv
// Directed bench for axi_burst_seq: a small generator/slave responder task
// answers the sequencer while the main sequence runs each scenario and checks
// results against hand-computed values.
module tb_axi_burst_seq;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cfg_start;
   logic        busy, done, resp_err, timeout;
   logic [15:0] err_count;
   logic        tg_start, tg_w_r;
   logic [3:0]  tg_burst_len;
   logic [7:0]  tg_data_strb;
   logic [63:0] tg_data;
   logic [31:0] tg_addr;
   logic        tg_free, tg_stall_w_data, tg_data_out_en;
   logic [1:0]  tg_status;
   logic [63:0] tg_data_out;

   int total = 0;
   int bad   = 0;

   // responder state and scenario knobs
   typedef enum int {G_IDLE, G_WRITE, G_READ} gen_st_t;
   gen_st_t     g_st;
   int          g_beat, g_txn_w, g_txn_r;
   int          wr_bad, rd_done_total;
   bit          tgl;
   bit          wready_toggle, aw_block, corrupt_en, bresp_en, short_en;
   logic [63:0] wr_cap [0:3][0:3];
   logic [31:0] wr_addr_cap [0:3];
   logic [31:0] rd_addr_cap [0:3];

   always #5 aclk = ~aclk;

   axi_burst_seq #(
      .ADDR_W      (32),
      .DATA_W      (64),
      .NUM_TXN     (4),
      .BURST_LEN   (3),
      .TIMEOUT_CYC (64)
   ) dut (
      .aclk            (aclk),
      .areset          (areset),
      .cfg_start       (cfg_start),
      .busy            (busy),
      .done            (done),
      .err_count       (err_count),
      .resp_err        (resp_err),
      .timeout         (timeout),
      .tg_start        (tg_start),
      .tg_w_r          (tg_w_r),
      .tg_burst_len    (tg_burst_len),
      .tg_data_strb    (tg_data_strb),
      .tg_data         (tg_data),
      .tg_addr         (tg_addr),
      .tg_free         (tg_free),
      .tg_stall_w_data (tg_stall_w_data),
      .tg_status       (tg_status),
      .tg_data_out     (tg_data_out),
      .tg_data_out_en  (tg_data_out_en)
   );

   function automatic logic [63:0] exp_word(input int t, input int b);
      logic [31:0] lane;
      lane = 32'hA5A5_0000 + 32'(t * 16) + 32'(b);
      return {lane, lane};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Generator + slave model, acting on falling edges.
   task gen_model();
      forever begin
         @(negedge aclk);
         if (areset) begin
            g_st = G_IDLE; g_beat = 0; g_txn_w = 0; g_txn_r = 0; tgl = 1'b0;
            tg_free = 1'b1; tg_stall_w_data = 1'b0; tg_data_out_en = 1'b0; tg_status = 2'b00;
         end else begin
            tg_status = 2'b00;
            if (done) begin
               g_txn_w = 0;
               g_txn_r = 0;
            end
            case (g_st)
               G_IDLE: begin
                  tg_stall_w_data = 1'b0;
                  tg_data_out_en  = 1'b0;
                  if (tg_start && !aw_block) begin
                     tg_free = 1'b0;
                     g_beat  = 0;
                     tgl     = 1'b0;
                     if (!tg_w_r) begin
                        if (g_txn_w < 4) wr_addr_cap[g_txn_w] = tg_addr;
                        g_st = G_WRITE;
                     end else begin
                        if (g_txn_r < 4) rd_addr_cap[g_txn_r] = tg_addr;
                        g_st = G_READ;
                     end
                  end else begin
                     tg_free = 1'b1;
                  end
               end
               G_WRITE: begin
                  tgl = ~tgl;
                  if (g_beat == 4) begin
                     tg_stall_w_data = 1'b0;
                     tg_free         = 1'b1;
                     if (bresp_en && g_txn_w == 0) tg_status = 2'b10;
                     g_txn_w++;
                     g_st = G_IDLE;
                  end else begin
                     if (tg_data !== exp_word(g_txn_w, g_beat) || tg_data_strb !== 8'hFF ||
                         tg_burst_len !== 4'd3 || tg_w_r !== 1'b0)
                        wr_bad++;
                     if (!wready_toggle || tgl) begin
                        tg_stall_w_data = 1'b1;
                        if (g_txn_w < 4) wr_cap[g_txn_w][g_beat] = tg_data;
                        g_beat++;
                     end else begin
                        tg_stall_w_data = 1'b0;
                     end
                  end
               end
               G_READ: begin
                  if (g_beat == ((short_en && g_txn_r == 2) ? 3 : 4)) begin
                     tg_data_out_en = 1'b0;
                     tg_free        = 1'b1;
                     g_txn_r++;
                     rd_done_total++;
                     g_st = G_IDLE;
                  end else begin
                     tg_data_out_en = 1'b1;
                     tg_data_out    = exp_word(g_txn_r, g_beat) ^
                                      ((corrupt_en && g_txn_r == 1 && g_beat == 2) ? 64'h1 : 64'h0);
                     g_beat++;
                  end
               end
               default: g_st = G_IDLE;
            endcase
         end
      end
   endtask

   // One full run; optionally re-pulses cfg_start mid-run (must be ignored).
   task automatic run_check(input string tag, input bit poke);
      int cyc;
      bit seen, poked;
      @(negedge aclk); #1 cfg_start = 1'b1;
      @(negedge aclk);
      chk({tag, "_busy"}, busy, 1'b1);
      #1 cfg_start = 1'b0;
      seen = 1'b0; poked = 1'b0; cyc = 0;
      while (!seen && cyc < 2000) begin
         @(negedge aclk);
         cyc++;
         if (done) seen = 1'b1;
         #1 cfg_start = poke && !poked && (g_txn_r == 2);
         if (cfg_start) poked = 1'b1;
      end
      cfg_start = 1'b0;
      chk({tag, "_done_seen"}, seen, 1'b1);
      @(negedge aclk);
      chk({tag, "_done_1cyc"}, done, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_start"}, tg_start, 1'b0);
      chk({tag, "_w_r"}, tg_w_r, 1'b0);
      chk({tag, "_blen"}, tg_burst_len, 4'd0);
      chk({tag, "_strb"}, tg_data_strb, 8'h00);
      chk({tag, "_data"}, tg_data, 64'h0);
      chk({tag, "_addr"}, tg_addr, 32'h0);
      chk({tag, "_err"}, err_count, 16'd0);
      chk({tag, "_resp"}, resp_err, 1'b0);
      chk({tag, "_tmo"}, timeout, 1'b0);
   endtask

   initial begin
      int wb0, rd0, starts, cyc;
      bit seen;
      areset = 1'b1; cfg_start = 1'b0;
      tg_free = 1'b1; tg_stall_w_data = 1'b0; tg_data_out_en = 1'b0;
      tg_status = 2'b00; tg_data_out = 64'h0;
      wready_toggle = 1'b0; aw_block = 1'b0; corrupt_en = 1'b0; bresp_en = 1'b0; short_en = 1'b0;
      wr_bad = 0; rd_done_total = 0;
      fork
         gen_model();
      join_none
      repeat (3) @(negedge aclk);
      chk_outputs_zero("reset");
      #1 areset = 1'b0;

      // 1: slave always ready
      wb0 = wr_bad; rd0 = rd_done_total;
      run_check("ready", 1'b0);
      chk("ready_err", err_count, 16'd0);
      chk("ready_resp", resp_err, 1'b0);
      chk("ready_tmo", timeout, 1'b0);
      chk("ready_wr_bad", wr_bad - wb0, 0);
      chk("ready_pairs", rd_done_total - rd0, 4);
      chk("ready_wd00", wr_cap[0][0], 64'hA5A50000_A5A50000);
      chk("ready_wd03", wr_cap[0][3], 64'hA5A50003_A5A50003);
      chk("ready_wd12", wr_cap[1][2], 64'hA5A50012_A5A50012);
      chk("ready_wd33", wr_cap[3][3], 64'hA5A50033_A5A50033);

      // 2: wready toggling, address sequence
      for (int i = 0; i < 4; i++) begin
         wr_addr_cap[i] = 32'h0;
         rd_addr_cap[i] = 32'h0;
      end
      wready_toggle = 1'b1;
      wb0 = wr_bad; rd0 = rd_done_total;
      run_check("toggle", 1'b0);
      chk("toggle_err", err_count, 16'd0);
      chk("toggle_wr_bad", wr_bad - wb0, 0);
      chk("toggle_pairs", rd_done_total - rd0, 4);
      chk("toggle_wa0", wr_addr_cap[0], 32'h0000_1000);
      chk("toggle_wa1", wr_addr_cap[1], 32'h0000_1100);
      chk("toggle_wa2", wr_addr_cap[2], 32'h0000_1200);
      chk("toggle_wa3", wr_addr_cap[3], 32'h0000_1300);
      chk("toggle_ra1", rd_addr_cap[1], 32'h0000_1100);
      chk("toggle_ra3", rd_addr_cap[3], 32'h0000_1300);
      wready_toggle = 1'b0;

      // 3: corrupted beat, plus an ignored cfg_start mid-run
      corrupt_en = 1'b1;
      run_check("corrupt", 1'b1);
      chk("corrupt_err", err_count, 16'd1);
      chk("corrupt_resp", resp_err, 1'b0);
      chk("corrupt_tmo", timeout, 1'b0);
      corrupt_en = 1'b0;

      // 4: short read burst on txn 2
      short_en = 1'b1;
      run_check("short", 1'b0);
      chk("short_err", err_count, 16'd1);
      short_en = 1'b0;

      // 5: error write response on txn 0
      bresp_en = 1'b1;
      rd0 = rd_done_total;
      run_check("bresp", 1'b0);
      chk("bresp_resp", resp_err, 1'b1);
      chk("bresp_err", err_count, 16'd0);
      chk("bresp_pairs", rd_done_total - rd0, 4);
      bresp_en = 1'b0;

      // 6: address never accepted -> watchdog after 64 cycles in WR_ISSUE
      aw_block = 1'b1;
      @(negedge aclk); #1 cfg_start = 1'b1;
      starts = 0; seen = 1'b0; cyc = 0;
      while (!seen && cyc < 300) begin
         @(negedge aclk);
         cyc++;
         if (tg_start) starts++;
         if (done) seen = 1'b1;
         #1 cfg_start = 1'b0;
      end
      chk("wd_done_seen", seen, 1'b1);
      chk("wd_start_cycles", starts, 64);
      chk("wd_timeout", timeout, 1'b1);
      chk("wd_err", err_count, 16'd0);
      chk("wd_resp_cleared", resp_err, 1'b0);
      @(negedge aclk);
      chk("wd_idle", busy, 1'b0);
      chk("wd_start_low", tg_start, 1'b0);
      chk("wd_sticky", timeout, 1'b1);
      #1 aw_block = 1'b0;

      // 7: reset in the middle of a read burst, then a clean run
      @(negedge aclk); #1 cfg_start = 1'b1;
      @(negedge aclk); #1 cfg_start = 1'b0;
      seen = 1'b0; cyc = 0;
      while (!seen && cyc < 500) begin
         @(negedge aclk); #1;
         cyc++;
         if (g_st == G_READ && g_beat >= 2) seen = 1'b1;
      end
      chk("mid_rd_reached", seen, 1'b1);
      areset = 1'b1;
      @(negedge aclk);
      chk_outputs_zero("midrst");
      #1 areset = 1'b0;
      rd0 = rd_done_total; wb0 = wr_bad;
      run_check("after_rst", 1'b0);
      chk("after_rst_err", err_count, 16'd0);
      chk("after_rst_resp", resp_err, 1'b0);
      chk("after_rst_tmo", timeout, 1'b0);
      chk("after_rst_pairs", rd_done_total - rd0, 4);
      chk("after_rst_wr_bad", wr_bad - wb0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_burst_seq.md
Name: axi_burst_seq

Overview:
- Upstream command sequencer for the AXI burst traffic generator (tg_* ports connect to its user_* ports).
- Runs NUM_TXN write-then-readback burst pairs at consecutive addresses, driving a deterministic data pattern.
- Compares every read beat against the expected pattern and reports mismatch count, sticky response error and watchdog timeout.
- Used as the self-checking stimulus source in front of the AXI VIP slave.

Parameters:
ADDR_W, 32, address width (matches generator)
DATA_W, 64, data width, multiple of 32
NUM_TXN, 4, write/read pairs per run, 1..256
BURST_LEN, 3, AXI len field (beats-1), 0..15
BASE_ADDR, 32'h0000_1000, address of txn 0
ADDR_STRIDE, 32'h0000_0100, address increment per txn
PATTERN_SEED, 32'hA5A5_0000, pattern base
TIMEOUT_CYC, 1024, watchdog limit per wait state; 0 disables

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
cfg_start  in  1  one-cycle request to start a run
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
err_count  out  16  read mismatches, saturating
resp_err  out  1  sticky: any nonzero bresp/rresp seen
timeout  out  1  sticky: watchdog fired
tg_start  out  1  to generator user_start
tg_w_r  out  1  0 = write, 1 = read
tg_burst_len  out  4  to user_burst_len_in
tg_data_strb  out  DATA_W/8  to user_data_strb
tg_data  out  DATA_W  to user_data_in
tg_addr  out  ADDR_W  to user_addr_in
tg_free  in  1  from user_free
tg_stall_w_data  in  1  from user_stall_w_data (high = beat accepted, i.e. wready)
tg_status  in  2  from user_status
tg_data_out  in  DATA_W  from user_data_out
tg_data_out_en  in  1  from user_data_out_en

Behaviour:
- Reset: state IDLE; all outputs 0; txn/beat/watchdog counters 0. Generator must share the reset (inverted at top level). Reset mid-run aborts immediately with no drain.
- Pattern: word(t,b) = each 32-bit lane = PATTERN_SEED + (t<<4) + b, mod 2^32, replicated DATA_W/32 times. Address(t) = BASE_ADDR + t*ADDR_STRIDE, mod 2^ADDR_W.
- tg_data, tg_addr, tg_burst_len, tg_data_strb are combinational from registered state/t/b only; no input-to-output comb path.
- tg_data_strb is all-ones in WR_ISSUE/WR_DATA, else 0. tg_burst_len = BURST_LEN when busy, else 0.
- States: IDLE, WR_ISSUE, WR_DATA, RD_ISSUE, RD_DATA, NEXT, DONE.
- IDLE: cfg_start clears err_count/resp_err/timeout and sets t=0 -> WR_ISSUE. cfg_start while busy is ignored.
- WR_ISSUE: tg_start=1, tg_w_r=0, b=0. When tg_free==0 (address accepted) -> WR_DATA. tg_start drops on leaving.
- WR_DATA: aligned with generator WRITE state. If tg_stall_w_data && b<BURST_LEN, then b<=b+1 (mirrors generator beat counter). When tg_free==1 -> RD_ISSUE.
- RD_ISSUE: tg_start=1, tg_w_r=1, b=0. When tg_free==0 -> RD_DATA.
- RD_DATA: on each tg_data_out_en, compare tg_data_out with word(t,b); mismatch -> err_count+1 (saturates at 16'hFFFF); b<=b+1. When tg_free==1 -> NEXT.
- Short read: b != BURST_LEN+1 at exit from RD_DATA counts as one additional error.
- NEXT: if t==NUM_TXN-1 -> DONE, else t<=t+1 -> WR_ISSUE.
- DONE: done=1 for exactly one cycle -> IDLE. Results hold until the next accepted cfg_start.
- busy=1 in every state except IDLE.
- resp_err: set when tg_status!=0 in any non-IDLE state (the generator status is registered, so it lags by a cycle; NEXT/DONE cover the last one).
- Watchdog: counter clears on every state change, accepted write beat and read beat. If it reaches TIMEOUT_CYC in an ISSUE or DATA state, set timeout=1, drop tg_start, -> DONE.
- An accepted beat and a watchdog terminal count in the same cycle: the beat wins.

Decomposition:
- axi_burst_seq_pkg: state encoding, lane width constant (32), and a pattern function word(t,b,seed).
- One sub-module: axi_burst_seq_pattern, combinational word(t,b) generator; instanced twice, for write data and read expectation.

Test Plan:
- NUM_TXN=1, BURST_LEN=3, VIP slave always ready -> writes to 0x1000 carry lanes 0xA5A50000..0xA5A50003; readback matches; done pulses; err_count=0, resp_err=0, timeout=0.
- NUM_TXN=4, wready toggling every other cycle -> b holds while wready is low and tg_data stays stable; address sequence is 0x1000, 0x1100, 0x1200, 0x1300; err_count=0.
- Slave corrupts txn 1 beat 2 on readback -> err_count=1, other results clean.
- Slave returns bresp=2'b10 on txn 0 -> resp_err=1; all 4 pairs still run; done pulses.
- awready held low, TIMEOUT_CYC=64 -> tg_start drops and timeout=1 after 64 cycles in WR_ISSUE; done pulses; err_count=0.
- areset asserted mid RD_DATA for 1 cycle -> next cycle all outputs 0 and state IDLE; a following cfg_start completes a clean run.
